// File: rtl/shake_pkg.sv
// Shared constants, FSM encoding and byte-placement helper for the SHAKE256 absorb front end.
package shake_pkg;

  localparam int         STATE_W        = 1600;
  localparam int         RATE_BYTES_256 = 136;
  localparam logic [7:0] DS_SHAKE       = 8'h1F;
  localparam logic [7:0] PAD_END        = 8'h80;

  typedef enum logic [1:0] {
    ST_ABSORB,
    ST_PAD,
    ST_PERMUTE,
    ST_OUTPUT
  } absorb_state_t;

  // State byte k occupies S[1599-8k -: 8]; this returns the low bit of that byte.
  function automatic int byte_lsb(input int k);
    return STATE_W - 1 - 8 * k - 7;
  endfunction

endpackage

// File: rtl/shake256_absorb_if.sv
// Message stream, permutation handshake and squeeze hand-off of the SHAKE256 absorb stage.
interface shake256_absorb_if;
  import shake_pkg::*;

  logic [63:0]        msg_data;
  logic [3:0]         msg_bytes;
  logic               msg_valid;
  logic               msg_last;
  logic               msg_ready;

  logic               perm_start;
  logic [STATE_W-1:0] perm_state;
  logic [STATE_W-1:0] perm_result;
  logic               perm_done;

  logic [STATE_W-1:0] state_out;
  logic               state_valid;
  logic               state_ack;

  // Environment side: message source, KECCAK_f core and squeeze stage.
  modport master (
    output msg_data, msg_bytes, msg_valid, msg_last,
    input  msg_ready,
    input  perm_start, perm_state,
    output perm_result, perm_done,
    input  state_out, state_valid,
    output state_ack
  );

  // Absorb engine side.
  modport slave (
    input  msg_data, msg_bytes, msg_valid, msg_last,
    output msg_ready,
    output perm_start, perm_state,
    input  perm_result, perm_done,
    output state_out, state_valid,
    input  state_ack
  );

endinterface

// File: rtl/shake256_byte_xor.sv
// Combinational XOR of up to eight left-justified bytes into the 1600-bit state at byte offset ptr.
module shake256_byte_xor
  import shake_pkg::*;
(
  input  logic [STATE_W-1:0] state_in,
  input  logic [63:0]        word,
  input  logic [7:0]         ptr,
  input  logic [3:0]         nbytes,
  output logic [STATE_W-1:0] state_out
);

  logic [63:0]        word_masked;
  logic [STATE_W-1:0] lane;

  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
    word_masked = '0;
    for (int j = 0; j < 8; j++) begin
      if (4'(j) < nbytes) word_masked[63-8*j -: 8] = word[63-8*j -: 8];
    end
    // Byte 0 of the word sits at state byte 0; shifting right by 8*ptr moves it to state byte ptr.
    lane      = {word_masked, {(STATE_W-64){1'b0}}} >> {ptr, 3'b000};
    state_out = state_in ^ lane;
  end

endmodule

// File: rtl/shake256_absorb.sv
// SHAKE256 absorb front end: XORs message words into the rate, pads, and sequences KECCAK_f per block.
module shake256_absorb
  import shake_pkg::*;
#(
  parameter int         RATE_BYTES = RATE_BYTES_256,
  parameter logic [7:0] DS_BYTE    = DS_SHAKE
) (
  input logic              clock,
  input logic              reset,
  shake256_absorb_if.slave bus
);

  localparam logic [7:0] PTR_FULL = 8'(RATE_BYTES);
  localparam logic [7:0] PTR_LAST = 8'(RATE_BYTES - 1);

  absorb_state_t      fsm_q, fsm_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic [7:0]         ptr_q, ptr_d;
  logic               final_pending_q, final_pending_d;
  logic               pad_done_q, pad_done_d;
  logic               started_q, started_d;

  logic [63:0]        xor_word;
  logic [3:0]         xor_bytes;
  logic [STATE_W-1:0] s_word;
  logic [STATE_W-1:0] s_padded;
  logic [7:0]         ptr_sum;

  // The first XOR carries the message word in ABSORB and the domain byte in PAD.
  always_comb begin
    xor_word  = bus.msg_data;
    xor_bytes = bus.msg_bytes;
    if (fsm_q == ST_PAD) begin
      xor_word  = {DS_BYTE, 56'h0};
      xor_bytes = 4'd1;
    end
  end

  shake256_byte_xor u_xor_word (
    .state_in  (s_q),
    .word      (xor_word),
    .ptr       (ptr_q),
    .nbytes    (xor_bytes),
    .state_out (s_word)
  );

  // Closing pad bit lands on the last rate byte; stacking it after the domain byte gives 0x9F at ptr=135.
  shake256_byte_xor u_xor_end (
    .state_in  (s_word),
    .word      ({PAD_END, 56'h0}),
    .ptr       (PTR_LAST),
    .nbytes    (4'd1),
    .state_out (s_padded)
  );

  assign ptr_sum = ptr_q + {4'h0, bus.msg_bytes};

  always_comb begin
    fsm_d           = fsm_q;
    s_d             = s_q;
    ptr_d           = ptr_q;
    final_pending_d = final_pending_q;
    pad_done_d      = pad_done_q;
    started_d       = started_q;
    bus.msg_ready   = 1'b0;
    bus.perm_start  = 1'b0;
    bus.state_valid = 1'b0;

    case (fsm_q)
      ST_ABSORB: begin
        bus.msg_ready = 1'b1;
        if (bus.msg_valid) begin
          s_d   = s_word;
          ptr_d = ptr_sum;
          if (bus.msg_last) final_pending_d = 1'b1;
          if (ptr_sum == PTR_FULL) fsm_d = ST_PERMUTE;
          else if (bus.msg_last)   fsm_d = ST_PAD;
        end
      end

      ST_PAD: begin
        s_d        = s_padded;
        pad_done_d = 1'b1;
        fsm_d      = ST_PERMUTE;
      end

      ST_PERMUTE: begin
        // perm_done is only honoured once the start pulse has gone out.
        if (!started_q) begin
          bus.perm_start = 1'b1;
          started_d      = 1'b1;
        end else if (bus.perm_done) begin
          s_d       = bus.perm_result;
          ptr_d     = '0;
          started_d = 1'b0;
          if (pad_done_q)           fsm_d = ST_OUTPUT;
          else if (final_pending_q) fsm_d = ST_PAD;
          else                      fsm_d = ST_ABSORB;
        end
      end

      ST_OUTPUT: begin
        bus.state_valid = 1'b1;
        if (bus.state_ack) begin
          s_d             = '0;
          ptr_d           = '0;
          final_pending_d = 1'b0;
          pad_done_d      = 1'b0;
          fsm_d           = ST_ABSORB;
        end
      end

      default: fsm_d = ST_ABSORB;
    endcase
  end

  assign bus.perm_state = s_q;
  assign bus.state_out  = s_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the sponge state is a plain register, not a memory, so it is cleared with everything else.
      fsm_q           <= ST_ABSORB;
      s_q             <= '0;
      ptr_q           <= '0;
      final_pending_q <= 1'b0;
      pad_done_q      <= 1'b0;
      started_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      fsm_q           <= fsm_d;
      s_q             <= s_d;
      ptr_q           <= ptr_d;
      final_pending_q <= final_pending_d;
      pad_done_q      <= pad_done_d;
      started_q       <= started_d;
    end
  end

endmodule
